// File: rtl/cnn1d_pkg.sv
// Shared types and helpers for the cnn1d datapath slice.
//   req_id_t      : requester ID wide enough for the largest supported arbiter
//   issue_state_t : issue-side lock state of exp_arbiter
//   rr_pick()     : round-robin pick over a request mask starting at a pointer
package cnn1d_pkg;

    localparam int unsigned MAX_REQ      = 32;
    localparam int unsigned MAX_ID_WIDTH = $clog2(MAX_REQ);

    // Users narrow this to their own ID_WIDTH with a size cast.
    typedef logic [MAX_ID_WIDTH-1:0] req_id_t;

    typedef enum logic {
        ISSUE_IDLE,
        ISSUE_HOLD
    } issue_state_t;

    // First set bit of mask[n-1:0] at or after ptr, searching cyclically.
    // Returns 0 when the mask is empty; callers qualify with |mask.
    function automatic req_id_t rr_pick(input logic [MAX_REQ-1:0] mask,
                                        input int unsigned        ptr,
                                        input int unsigned        n);
        req_id_t     pick;
        logic        found;
        int unsigned idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && mask[idx[MAX_ID_WIDTH-1:0]]) begin
                    pick  = req_id_t'(idx);
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/exp_tag_fifo.sv
// In-order tag FIFO holding the requester ID of each operand issued to the
// exp unit and not yet returned.
//   clk, rst        : clock, asynchronous active-low reset
//   push, push_data : enqueue one tag (ignored when full)
//   pop, pop_data   : dequeue head tag (ignored when empty); pop_data = head
//   full, empty     : occupancy flags
//   count           : number of stored tags, 0..DEPTH
module exp_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/exp_arbiter.sv
// Shares one in-order pipelined exp unit between NUM_REQ ready/valid lanes.
// Operands are granted round-robin and forwarded combinationally; each issued
// lane ID is logged in a tag FIFO so results route back to their origin.
//   clk, rst                         : clock, asynchronous active-low reset
//   arb_valid_in/ready_in/data_in    : per-lane operand channel
//   arb_valid_out/ready_out/data_out : per-lane result channel (data broadcast)
//   exp_valid_in/ready_in/data_in    : operand channel to the exp unit
//   exp_valid_out/ready_out/data_out : result channel from the exp unit
//   arb_err                          : sticky, result seen with no tag pending
module exp_arbiter
    import cnn1d_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = 12,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              arb_valid_in,
    output logic [NUM_REQ-1:0]              arb_ready_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   arb_data_in,
    output logic [NUM_REQ-1:0]              arb_valid_out,
    input  logic [NUM_REQ-1:0]              arb_ready_out,
    output logic [NUM_REQ*DATA_WIDTH-1:0]   arb_data_out,
    output logic                            exp_valid_in,
    input  logic                            exp_ready_in,
    output logic [DATA_WIDTH-1:0]           exp_data_in,
    input  logic                            exp_valid_out,
    output logic                            exp_ready_out,
    input  logic [DATA_WIDTH-1:0]           exp_data_out,
    output logic                            arb_err
);

    localparam int ID_WIDTH = $clog2(NUM_REQ);
    localparam int CNT_W    = $clog2(MAX_OUTSTANDING) + 1;

    issue_state_t          state_q, state_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q;
    logic [ID_WIDTH-1:0]   locked_id_q;
    logic [ID_WIDTH-1:0]   grant_id;
    logic [ID_WIDTH-1:0]   head_id;
    logic                  grant_vld;
    logic                  xfer;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  unused_count;

    assign unused_count = ^fifo_count;

    // Issue side. Grant is gated by rst so every output is low while reset is
    // held, even though the lane valids are not.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = rr_ptr_q;
        if (rst) begin
            if (state_q == ISSUE_HOLD) begin
                grant_vld = 1'b1;
                grant_id  = locked_id_q;
            end else if (!fifo_full && (|arb_valid_in)) begin
                grant_vld = 1'b1;
                grant_id  = ID_WIDTH'(rr_pick(MAX_REQ'(arb_valid_in),
                                              32'(rr_ptr_q), NUM_REQ));
            end
        end
    end

    assign xfer = grant_vld & exp_ready_in;

    always_comb begin
        exp_valid_in = grant_vld;
        exp_data_in  = '0;
        arb_ready_in = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_WIDTH'(i)) begin
                exp_data_in     = arb_data_in[i*DATA_WIDTH +: DATA_WIDTH];
                arb_ready_in[i] = grant_vld & exp_ready_in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ISSUE_IDLE: if (grant_vld && !exp_ready_in) state_d = ISSUE_HOLD;
            ISSUE_HOLD: if (exp_ready_in)               state_d = ISSUE_IDLE;
            default:    state_d = ISSUE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ISSUE_IDLE;
            locked_id_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ISSUE_IDLE && state_d == ISSUE_HOLD) begin
                locked_id_q <= grant_id;
            end
            if (xfer) begin
                rr_ptr_q <= (grant_id == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

    // Return side: only the head tag's lane sees the result, and its ready
    // alone backpressures the exp unit.
    always_comb begin
        arb_valid_out = '0;
        exp_ready_out = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!fifo_empty && head_id == ID_WIDTH'(i)) begin
                arb_valid_out[i] = exp_valid_out;
                exp_ready_out    = arb_ready_out[i];
            end
        end
    end

    assign pop          = exp_valid_out & exp_ready_out;
    assign arb_data_out = {NUM_REQ{exp_data_out}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arb_err <= 1'b0;
        end else if (exp_valid_out && fifo_empty) begin
            arb_err <= 1'b1;
        end
    end

    exp_tag_fifo #(
        .WIDTH (ID_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (xfer),
        .push_data (grant_id),
        .pop       (pop),
        .pop_data  (head_id),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_exp_arbiter.sv
module tb_exp_arbiter;

    localparam int NR = 4;
    localparam int DW = 12;
    localparam int MO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     arb_valid_in;
    logic [NR-1:0]     arb_ready_in;
    logic [NR*DW-1:0]  arb_data_in;
    logic [NR-1:0]     arb_valid_out;
    logic [NR-1:0]     arb_ready_out;
    logic [NR*DW-1:0]  arb_data_out;
    logic              exp_valid_in;
    logic              exp_ready_in;
    logic [DW-1:0]     exp_data_in;
    logic              exp_valid_out;
    logic              exp_ready_out;
    logic [DW-1:0]     exp_data_out;
    logic              arb_err;

    always #5 clk = ~clk;

    exp_arbiter #(
        .NUM_REQ         (NR),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .arb_valid_in  (arb_valid_in),
        .arb_ready_in  (arb_ready_in),
        .arb_data_in   (arb_data_in),
        .arb_valid_out (arb_valid_out),
        .arb_ready_out (arb_ready_out),
        .arb_data_out  (arb_data_out),
        .exp_valid_in  (exp_valid_in),
        .exp_ready_in  (exp_ready_in),
        .exp_data_in   (exp_data_in),
        .exp_valid_out (exp_valid_out),
        .exp_ready_out (exp_ready_out),
        .exp_data_out  (exp_data_out),
        .arb_err       (arb_err)
    );

    typedef struct packed {
        logic [1:0]    lane;
        logic [DW-1:0] data;
    } sb_t;

    typedef struct {
        logic [DW-1:0] res;
        int unsigned   due;
    } mdl_t;

    sb_t           iss_q[$];
    sb_t           ret_q[$];
    logic [DW-1:0] lane_q[NR][$];
    mdl_t          mdl_q[$];
    sb_t           e_iss;
    sb_t           e_ret;
    mdl_t          m_new;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;
    int unsigned lat   = 4;
    logic        force_ev = 1'b0;

    logic [NR-1:0] req_fire = '0;
    logic          iss_fire = 1'b0;
    logic [DW-1:0] iss_data = '0;
    logic          exp_pop  = 1'b0;

    // Stand-in exp function: result = operand + 0x100.
    function automatic logic [DW-1:0] exp_fn(input logic [DW-1:0] x);
        return x + 12'h100;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic expect_op(input int lane, input logic [DW-1:0] op, input logic [DW-1:0] res);
        iss_q.push_back('{lane: 2'(lane), data: op});
        ret_q.push_back('{lane: 2'(lane), data: res});
    endtask

    // Monitor: sample handshakes mid-cycle, compare against the scoreboard.
    initial forever begin
        @(negedge clk);
        iss_fire = exp_valid_in & exp_ready_in;
        iss_data = exp_data_in;
        req_fire = arb_valid_in & arb_ready_in;
        exp_pop  = exp_valid_out & exp_ready_out;
        if (iss_fire) begin
            if (iss_q.size() == 0) begin
                chk("spurious_issue", 32'(arb_ready_in), 32'(0));
            end else begin
                e_iss = iss_q.pop_front();
                chk("issue_grant", 32'(arb_ready_in), 32'(1) << e_iss.lane);
                chk("issue_data", 32'(exp_data_in), 32'(e_iss.data));
            end
        end
        if ((arb_valid_out & arb_ready_out) != '0) begin
            if (ret_q.size() == 0) begin
                chk("spurious_return", 32'(arb_valid_out), 32'(0));
            end else begin
                e_ret = ret_q.pop_front();
                chk("ret_lane", 32'(arb_valid_out), 32'(1) << e_ret.lane);
                chk("ret_data", 32'(arb_data_out[e_ret.lane*DW +: DW]), 32'(e_ret.data));
            end
        end
    end

    // Lane requesters and exp unit model, updated just after each edge.
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NR; i++) begin
            if (req_fire[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
        end
        if (iss_fire) begin
            m_new.res = exp_fn(iss_data);
            m_new.due = cyc + lat;
            mdl_q.push_back(m_new);
        end
        if (exp_pop && mdl_q.size() > 0) void'(mdl_q.pop_front());
        iss_fire = 1'b0;
        exp_pop  = 1'b0;
        req_fire = '0;
        for (int i = 0; i < NR; i++) begin
            arb_valid_in[i]          = (lane_q[i].size() > 0);
            arb_data_in[i*DW +: DW]  = (lane_q[i].size() > 0) ? lane_q[i][0] : '0;
        end
        if (force_ev) begin
            exp_valid_out = 1'b1;
        end else if (mdl_q.size() > 0 && mdl_q[0].due <= cyc) begin
            exp_valid_out = 1'b1;
            exp_data_out  = mdl_q[0].res;
        end else begin
            exp_valid_out = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic flush();
        for (int i = 0; i < NR; i++) lane_q[i].delete();
        mdl_q.delete();
        iss_q.delete();
        ret_q.delete();
        force_ev      = 1'b0;
        exp_valid_out = 1'b0;
        arb_valid_in  = '0;
    endtask

    task automatic chk_outputs_low(input string nm);
        chk(nm, 32'({arb_ready_in, arb_valid_out, exp_valid_in, exp_ready_out, arb_err}), 32'(0));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        flush();
        #1;
        chk_outputs_low("reset_outputs");
        step(3);
        rst = 1'b1;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n;
        n = 0;
        while ((iss_q.size() != 0 || ret_q.size() != 0) && n < budget) begin
            step(1);
            n++;
        end
        chk(nm, 32'(iss_q.size() + ret_q.size()), 32'(0));
    endtask

    initial begin
        rst           = 1'b1;
        arb_valid_in  = '0;
        arb_data_in   = '0;
        arb_ready_out = '1;
        exp_ready_in  = 1'b1;
        exp_valid_out = 1'b0;
        exp_data_out  = '0;
        #3;

        // Single operand from lane 0, latency 4.
        do_reset();
        lat = 4;
        expect_op(0, 12'h200, 12'h300);
        lane_q[0].push_back(12'h200);
        wait_idle("t1_drain", 30);
        chk("t1_no_err", 32'(arb_err), 32'(0));

        // All four lanes streaming: round-robin 0,1,2,3 repeated.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NR; i++) begin
                expect_op(i, 12'h040 + 12'(16*i + k), exp_fn(12'h040 + 12'(16*i + k)));
                lane_q[i].push_back(12'h040 + 12'(16*i + k));
            end
        end
        wait_idle("t2_drain", 80);

        // Stall while lane 2 granted; lane 1 arrives mid-stall -> order 2,3,1.
        do_reset();
        exp_ready_in = 1'b0;
        expect_op(2, 12'h321, exp_fn(12'h321));
        expect_op(3, 12'h0ab, exp_fn(12'h0ab));
        expect_op(1, 12'h155, exp_fn(12'h155));
        lane_q[2].push_back(12'h321);
        lane_q[3].push_back(12'h0ab);
        step(1);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("t3_hold", 32'({exp_valid_in, exp_data_in, arb_ready_in}), 32'({1'b1, 12'h321, 4'b0000}));
            step(1);
            if (j == 1) lane_q[1].push_back(12'h155);
        end
        exp_ready_in = 1'b1;
        wait_idle("t3_drain", 60);

        // Lane 0 blocks results; FIFO fills at 8, then drains in order.
        do_reset();
        lat           = 2;
        arb_ready_out = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 3; i++) begin
                expect_op(i, 12'h500 + 12'(16*i + k), exp_fn(12'h500 + 12'(16*i + k)));
                lane_q[i].push_back(12'h500 + 12'(16*i + k));
            end
        end
        begin
            int n;
            n = 0;
            while (iss_q.size() > 4 && n < 40) begin
                step(1);
                n++;
            end
        end
        step(3);
        @(negedge clk);
        chk("t4_full_stall", 32'({exp_valid_in, 8'(iss_q.size())}), 32'({1'b0, 8'd4}));
        @(posedge clk);
        #2;
        arb_ready_out = 4'b1111;
        @(negedge clk);
        chk("t4_pop_no_issue", 32'({exp_valid_in, exp_ready_out, exp_valid_out}), 32'(3'b011));
        @(negedge clk);
        chk("t4_resume", 32'(exp_valid_in), 32'(1));
        wait_idle("t4_drain", 80);

        // Result with nothing outstanding raises a sticky error.
        do_reset();
        lat = 4;
        step(1);
        force_ev      = 1'b1;
        exp_valid_out = 1'b1;
        exp_data_out  = 12'habc;
        @(negedge clk);
        chk("t5_no_route", 32'({arb_valid_out, exp_ready_out}), 32'(0));
        step(1);
        chk("t5_err_set", 32'(arb_err), 32'(1));
        force_ev      = 1'b0;
        exp_valid_out = 1'b0;
        step(3);
        chk("t5_err_sticky", 32'(arb_err), 32'(1));
        rst = 1'b0;
        #1;
        chk("t5_err_cleared", 32'(arb_err), 32'(0));

        // Reset with 5 outstanding and one operand held on lane 3.
        do_reset();
        lat = 20;
        expect_op(0, 12'h610, exp_fn(12'h610));
        expect_op(1, 12'h620, exp_fn(12'h620));
        expect_op(2, 12'h630, exp_fn(12'h630));
        expect_op(0, 12'h611, exp_fn(12'h611));
        expect_op(1, 12'h621, exp_fn(12'h621));
        lane_q[0].push_back(12'h610);
        lane_q[0].push_back(12'h611);
        lane_q[1].push_back(12'h620);
        lane_q[1].push_back(12'h621);
        lane_q[2].push_back(12'h630);
        begin
            int n;
            n = 0;
            while (iss_q.size() != 0 && n < 30) begin
                step(1);
                n++;
            end
            chk("t6_issued5", 32'(iss_q.size()), 32'(0));
        end
        exp_ready_in = 1'b0;
        lane_q[3].push_back(12'h7c3);
        step(2);
        chk("t6_hold_lane3", 32'({exp_valid_in, exp_data_in}), 32'({1'b1, 12'h7c3}));
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_outputs_low("t6_async_low");
        flush();
        lat          = 4;
        exp_ready_in = 1'b1;
        lane_q[3].push_back(12'h7c3);
        lane_q[0].push_back(12'h0d0);
        expect_op(0, 12'h0d0, exp_fn(12'h0d0));
        expect_op(3, 12'h7c3, exp_fn(12'h7c3));
        step(2);
        chk("t6_gated_valids", 32'({arb_valid_in, arb_ready_in, exp_valid_in}), 32'({4'b1001, 4'b0000, 1'b0}));
        rst = 1'b1;
        #1;
        chk("t6_fifo_empty", 32'({exp_ready_out, arb_valid_out}), 32'(0));
        wait_idle("t6_drain", 40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
